// File: rtl/rs232_tx_buf.sv
// FIFO-buffered RS-232 transmitter: 8 data bits, no parity, 1 or 2 stop bits, LSB first.
// Queued bytes are framed back-to-back onto TxD with no idle gap between frames.
module rs232_tx_buf #(
    parameter int DIVISOR   = 1302,
    parameter int DEPTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       rdy,
    output logic       busy,
    output logic [4:0] count,
    output logic       ovf,
    output logic       TxD
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [11:0] TICK_MAX  = 12'(DIVISOR - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [DEPTH-1:0][7:0] mem;
    logic [AW-1:0]        wptr, rptr;
    logic [11:0]          tick;
    logic [2:0]           bitidx;
    logic [7:0]           shreg;
    logic                 wr, pop, period_end, nonempty;

    assign rdy        = (count != 5'(DEPTH));
    assign nonempty   = (count != 5'd0);
    assign busy       = (state != IDLE) | nonempty;
    assign wr         = start & rdy;
    assign period_end = (tick == TICK_MAX);
    // The FSM loads a byte from IDLE, or straight from the end of the last stop bit.
    assign pop        = nonempty & ((state == IDLE) |
                        ((state == STOP) & period_end & (bitidx == LAST_STOP)));

    always_ff @(posedge clk) begin
        if (rst && wr)
            mem[wptr] <= data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= 5'd0;
            ovf   <= 1'b0;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            if (wr && !pop)
                count <= count + 5'd1;
            else if (!wr && pop)
                count <= count - 5'd1;
            if (start && !rdy)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            tick   <= 12'd0;
            bitidx <= 3'd0;
            shreg  <= 8'd0;
            TxD    <= 1'b1;
        end else begin
            if (state == IDLE || period_end)
                tick <= 12'd0;
            else
                tick <= tick + 12'd1;
            case (state)
                IDLE: begin
                    TxD <= 1'b1;
                    if (pop) begin
                        shreg <= mem[rptr];
                        state <= START;
                        TxD   <= 1'b0;
                    end
                end
                START: begin
                    if (period_end) begin
                        state  <= DATA;
                        bitidx <= 3'd0;
                        TxD    <= shreg[0];
                    end
                end
                DATA: begin
                    if (period_end) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bitidx == 3'd7) begin
                            state  <= STOP;
                            bitidx <= 3'd0;
                            TxD    <= 1'b1;
                        end else begin
                            bitidx <= bitidx + 3'd1;
                            TxD    <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    // bitidx is reused here to count stop bits.
                    if (period_end) begin
                        if (bitidx != LAST_STOP) begin
                            bitidx <= bitidx + 3'd1;
                        end else if (pop) begin
                            shreg  <= mem[rptr];
                            bitidx <= 3'd0;
                            state  <= START;
                            TxD    <= 1'b0;
                        end else begin
                            bitidx <= 3'd0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs232_tx_buf.sv
// Bench for rs232_tx_buf: scoreboard of queued bytes checked bit-by-bit against TxD
// on two instances (1 stop bit / DIVISOR 4, 2 stop bits / DIVISOR 5).
module tb_rs232_tx_buf;
    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] data0  = 8'd0, data1  = 8'd0;
    logic       rdy0, busy0, ovf0, tx0;
    logic       rdy1, busy1, ovf1, tx1;
    logic [4:0] count0, count1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  q0[$], q1[$];
    int          fst0[$], fst1[$];
    logic [10:0] pat [2];
    int          n   [2];
    bit          inf [2];

    rs232_tx_buf #(.DIVISOR(4), .DEPTH(4), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data(data0), .rdy(rdy0),
        .busy(busy0), .count(count0), .ovf(ovf0), .TxD(tx0)
    );

    rs232_tx_buf #(.DIVISOR(5), .DEPTH(4), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data(data1), .rdy(rdy1),
        .busy(busy1), .count(count1), .ovf(ovf1), .TxD(tx1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input logic [7:0] b, input bit accepted);
        if (ch == 0) begin
            start0 = 1'b1;
            data0  = b;
            if (accepted) q0.push_back(b);
        end else begin
            start1 = 1'b1;
            data1  = b;
            if (accepted) q1.push_back(b);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input int ch, input int lim, input string tag);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge clk);
            if (((ch == 0) ? busy0 : busy1) == 1'b0) break;
        end
        check(tag, 32'(i < lim), 1);
    endtask

    // Line monitor: on each start bit pop the expected byte and check every cycle of the frame.
    always begin
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            logic       tx;
            int         d, len, qn;
            logic [7:0] b;
            tx  = (ch == 0) ? tx0 : tx1;
            d   = (ch == 0) ? 4 : 5;
            len = (ch == 0) ? 40 : 55;
            if (!rst) begin
                inf[ch] = 1'b0;
            end else begin
                if (!inf[ch] && tx == 1'b0) begin
                    qn = (ch == 0) ? q0.size() : q1.size();
                    check("frame_expected", 32'(qn != 0), 1);
                    if (qn != 0) begin
                        if (ch == 0) begin
                            b = q0.pop_front();
                            fst0.push_back(cyc);
                        end else begin
                            b = q1.pop_front();
                            fst1.push_back(cyc);
                        end
                        pat[ch] = {2'b11, b, 1'b0};
                        n[ch]   = 0;
                        inf[ch] = 1'b1;
                    end
                end
                if (inf[ch]) begin
                    check(ch == 0 ? "txd_bit0" : "txd_bit1", tx, pat[ch][n[ch] / d]);
                    n[ch]++;
                    if (n[ch] == len) inf[ch] = 1'b0;
                end
            end
        end
    end

    initial begin
        int k, s;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            check("idle0", {tx0, rdy0, busy0, count0, ovf0}, 9'b1_1_0_00000_0);
            check("idle1", {tx1, rdy1, busy1, count1, ovf1}, 9'b1_1_0_00000_0);
        end

        // single byte
        fst0.delete();
        k = cyc;
        wr(0, 8'hA5, 1);
        check("a5_count", count0, 1);
        check("a5_busy", busy0, 1);
        wait_idle(0, 100, "a5_idle");
        check("a5_busy_drop", cyc, k + 42);
        check("a5_fall", (fst0.size() > 0) ? fst0[0] : -1, k + 2);

        // burst of four
        fst0.delete();
        wr(0, 8'h00, 1);
        check("burst_cnt_a", {rdy0, count0}, {1'b1, 5'd1});
        wr(0, 8'hFF, 1);
        check("burst_cnt_b", {rdy0, count0}, {1'b1, 5'd1});
        wr(0, 8'h55, 1);
        check("burst_cnt_c", {rdy0, count0}, {1'b1, 5'd2});
        wr(0, 8'h81, 1);
        check("burst_cnt_d", {rdy0, count0}, {1'b1, 5'd3});
        wait_idle(0, 300, "burst_idle");
        check("burst_frames", fst0.size(), 4);
        if (fst0.size() == 4)
            for (int j = 1; j < 4; j++) check("burst_gap", fst0[j] - fst0[j-1], 40);
        check("burst_count_end", count0, 0);

        // overflow
        fst0.delete();
        wr(0, 8'h11, 1);
        wr(0, 8'h22, 1);
        wr(0, 8'h33, 1);
        wr(0, 8'h44, 1);
        wr(0, 8'h66, 1);
        check("full_state", {rdy0, ovf0, count0}, {1'b0, 1'b0, 5'd4});
        wr(0, 8'h3C, 0);
        check("ovf_set", ovf0, 1);
        check("ovf_count", count0, 4);
        wait_idle(0, 400, "ovf_idle");
        check("ovf_frames", fst0.size(), 5);
        check("ovf_sticky", ovf0, 1);
        check("ovf_count_end", count0, 0);

        // reset during data bit 3 of 0x0F with two bytes queued
        fst0.delete();
        k = cyc;
        s = k + 2;
        wr(0, 8'h0F, 1);
        wr(0, 8'hAA, 1);
        wr(0, 8'hBB, 1);
        check("pre_rst_count", count0, 2);
        check("pre_rst_ovf", ovf0, 1);
        while (cyc < s + 16) @(negedge clk);
        check("bit3_level", tx0, 1);
        rst = 1'b0;
        q0.delete();
        @(negedge clk);
        check("rst_state", {tx0, rdy0, busy0, count0, ovf0}, 9'b1_1_0_00000_0);
        rst = 1'b1;
        fst0.delete();
        for (int j = 0; j < 150; j++) begin
            @(negedge clk);
            check("post_rst_quiet", {tx0, busy0}, 2'b10);
        end
        check("post_rst_frames", fst0.size(), 0);

        // two stop bits, DIVISOR 5
        fst1.delete();
        k = cyc;
        wr(1, 8'h12, 1);
        wr(1, 8'h34, 1);
        wait_idle(1, 300, "sb2_idle");
        check("sb2_frames", fst1.size(), 2);
        if (fst1.size() == 2) begin
            check("sb2_first", fst1[0], k + 2);
            check("sb2_gap", fst1[1] - fst1[0], 55);
            check("sb2_end", cyc, fst1[0] + 110);
        end

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
